// File: rtl/dispatch_scoreboard_if.sv
// Issue / writeback bundle between the dispatch stage and the scoreboard.
// The dispatch side drives the issue_* fields and observes the ready,
// writeback and busy results; the scoreboard takes the opposite view.
interface dispatch_scoreboard_if #(
  parameter int unsigned LAT_W = 4
);
  logic             issue_valid;
  logic [4:0]       issue_rs1;
  logic [4:0]       issue_rs2;
  logic [4:0]       issue_rs3;
  logic             issue_use1;
  logic             issue_use2;
  logic             issue_use3;
  logic             issue_fp1;
  logic             issue_fp2;
  logic             issue_fp3;
  logic [4:0]       issue_rd;
  logic             issue_rd_we;
  logic             issue_rd_fp;
  logic [LAT_W-1:0] issue_lat;
  logic             issue_ready;
  logic             wb_valid;
  logic [4:0]       wb_rd;
  logic             wb_fp;
  logic             busy;

  modport master (
    output issue_valid, issue_rs1, issue_rs2, issue_rs3,
           issue_use1, issue_use2, issue_use3,
           issue_fp1, issue_fp2, issue_fp3,
           issue_rd, issue_rd_we, issue_rd_fp, issue_lat,
    input  issue_ready, wb_valid, wb_rd, wb_fp, busy
  );

  modport slave (
    input  issue_valid, issue_rs1, issue_rs2, issue_rs3,
           issue_use1, issue_use2, issue_use3,
           issue_fp1, issue_fp2, issue_fp3,
           issue_rd, issue_rd_we, issue_rd_fp, issue_lat,
    output issue_ready, wb_valid, wb_rd, wb_fp, busy
  );
endinterface

// File: rtl/dispatch_scoreboard.sv
// Issue-control scoreboard for fixed-latency operations. Tracks pending
// writes to the integer and FPU register files, blocks dispatch on RAW,
// WAW and writeback-port conflicts, and schedules the single writeback port
// through a reservation shift register whose entry k completes k cycles out.
module dispatch_scoreboard #(
  parameter int unsigned MAX_LAT = 8,
  parameter int unsigned LAT_W   = $clog2(MAX_LAT + 1)
) (
  input logic                 clk,
  input logic                 rst,
  dispatch_scoreboard_if.slave bus
);

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       fp;
  } entry_t;

  entry_t      resv     [MAX_LAT];
  entry_t      resv_nxt [MAX_LAT];
  logic [31:0] int_pend;
  logic [31:0] fp_pend;
  logic [31:0] int_pend_nxt;
  logic [31:0] fp_pend_nxt;

  logic raw;
  logic waw;
  logic lat_ok;
  logic slot_busy;
  logic ready;
  logic fire_wr;

  // Hazard evaluation from registered state and the presented instruction
  always_comb begin
    raw = (bus.issue_use1 & (bus.issue_fp1 ? fp_pend[bus.issue_rs1] : int_pend[bus.issue_rs1]))
        | (bus.issue_use2 & (bus.issue_fp2 ? fp_pend[bus.issue_rs2] : int_pend[bus.issue_rs2]))
        | (bus.issue_use3 & (bus.issue_fp3 ? fp_pend[bus.issue_rs3] : int_pend[bus.issue_rs3]));
    waw    = bus.issue_rd_fp ? fp_pend[bus.issue_rd] : int_pend[bus.issue_rd];
    lat_ok = (bus.issue_lat != '0) && (bus.issue_lat <= LAT_W'(MAX_LAT));
    // A latency of MAX_LAT lands in the slot refilled empty by the shift,
    // so only indices 1..MAX_LAT-1 can collide.
    slot_busy = 1'b0;
    for (int unsigned i = 1; i < MAX_LAT; i++) begin
      if (bus.issue_lat == LAT_W'(i)) slot_busy = resv[i].v;
    end
    ready   = ~raw & (~bus.issue_rd_we | (~waw & lat_ok & ~slot_busy));
    // Writes to integer register 0 are accepted but never tracked
    fire_wr = bus.issue_valid & ready & bus.issue_rd_we
            & (bus.issue_rd_fp | (bus.issue_rd != 5'd0));
  end

  // Next-state: shift reservations, insert new write, clear then set pending bits
  always_comb begin
    for (int unsigned i = 0; i < MAX_LAT - 1; i++) resv_nxt[i] = resv[i + 1];
    resv_nxt[MAX_LAT-1] = '0;
    if (fire_wr) begin
      for (int unsigned i = 0; i < MAX_LAT; i++) begin
        if (bus.issue_lat == LAT_W'(i + 1)) resv_nxt[i] = '{v: 1'b1, rd: bus.issue_rd, fp: bus.issue_rd_fp};
      end
    end
    int_pend_nxt = int_pend;
    fp_pend_nxt  = fp_pend;
    if (resv[0].v) begin
      if (resv[0].fp) fp_pend_nxt[resv[0].rd]  = 1'b0;
      else            int_pend_nxt[resv[0].rd] = 1'b0;
    end
    if (fire_wr) begin
      if (bus.issue_rd_fp) fp_pend_nxt[bus.issue_rd]  = 1'b1;
      else                 int_pend_nxt[bus.issue_rd] = 1'b1;
    end
    int_pend_nxt[0] = 1'b0;
  end

  // State registers; reset discards every in-flight write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resv     <= '{default: '0};
      int_pend <= '0;
      fp_pend  <= '0;
    end else begin
      resv     <= resv_nxt;
      int_pend <= int_pend_nxt;
      fp_pend  <= fp_pend_nxt;
    end
  end

  assign bus.issue_ready = ready;
  assign bus.wb_valid    = resv[0].v;
  assign bus.wb_rd       = resv[0].rd;
  assign bus.wb_fp       = resv[0].fp;
  assign bus.busy        = (|int_pend) | (|fp_pend);

endmodule
